// File: rtl/load_store_mem_access_stage_if.sv
// Bundle between the load/store memory access stage and its neighbours:
// upstream handshake, data memory port, register-file read/write ports.
interface load_store_mem_access_stage_if #(
    parameter int TAG_W  = 6,
    parameter int ADDR_W = 32
);
    logic              valid_in;
    logic              ready_out;
    logic [TAG_W-1:0]  instr_tag_in;
    logic              instr_exec_in;
    logic              ld_str_in;
    logic [1:0]        size_in;
    logic [ADDR_W-1:0] addr_in;
    logic [ADDR_W-1:0] str_data_in;
    logic [3:0]        rd_addr_in;
    logic              multiple_en_in;
    logic [15:0]       reg_list_in;
    logic [3:0]        rn_addr_in;
    logic [ADDR_W-1:0] rn_data_in;
    logic              base_wb_en_in;

    logic [3:0]        rf_rd_addr_out;
    logic [ADDR_W-1:0] rf_rd_data_in;

    logic              mem_req_out;
    logic              mem_we_out;
    logic [ADDR_W-1:0] mem_addr_out;
    logic [3:0]        mem_be_out;
    logic [ADDR_W-1:0] mem_wdata_out;
    logic              mem_ack_in;
    logic [ADDR_W-1:0] mem_rdata_in;

    logic              wb_en_out;
    logic [3:0]        wb_addr_out;
    logic [ADDR_W-1:0] wb_data_out;
    logic              done_out;
    logic [TAG_W-1:0]  done_tag_out;

    modport slave (
        input  valid_in, instr_tag_in, instr_exec_in, ld_str_in,
        input  size_in, addr_in, str_data_in, rd_addr_in,
        input  multiple_en_in, reg_list_in, rn_addr_in, rn_data_in,
        input  base_wb_en_in, rf_rd_data_in, mem_ack_in, mem_rdata_in,
        output ready_out, rf_rd_addr_out,
        output mem_req_out, mem_we_out, mem_addr_out, mem_be_out,
        output mem_wdata_out,
        output wb_en_out, wb_addr_out, wb_data_out,
        output done_out, done_tag_out
    );

    modport master (
        output valid_in, instr_tag_in, instr_exec_in, ld_str_in,
        output size_in, addr_in, str_data_in, rd_addr_in,
        output multiple_en_in, reg_list_in, rn_addr_in, rn_data_in,
        output base_wb_en_in, rf_rd_data_in, mem_ack_in, mem_rdata_in,
        input  ready_out, rf_rd_addr_out,
        input  mem_req_out, mem_we_out, mem_addr_out, mem_be_out,
        input  mem_wdata_out,
        input  wb_en_out, wb_addr_out, wb_data_out,
        input  done_out, done_tag_out
    );
endinterface

// File: rtl/load_store_mem_access_stage.sv
// Memory access stage: single LDR/STR and LDM/STM sequencing, load
// formatting, register writeback and tagged completion.
module load_store_mem_access_stage #(
    parameter int TAG_W  = 6,
    parameter int ADDR_W = 32
) (
    input  logic clk_in,
    input  logic reset_in,
    load_store_mem_access_stage_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        WB_BASE = 2'd2,
        FINISH  = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [TAG_W-1:0]  tag_q;
    logic              ld_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] sdata_q;
    logic [3:0]        rd_q;
    logic              mult_q;
    logic [15:0]       list_q;
    logic [3:0]        rn_q;
    logic [ADDR_W-1:0] rn_data_q;
    logic              bwb_q;

    logic              wb_en_q;
    logic [3:0]        wb_addr_q;
    logic [ADDR_W-1:0] wb_data_q;

    logic              accept;
    logic              acked;
    logic              more;
    logic [15:0]       list_rest;
    logic [3:0]        cur_idx;
    logic [1:0]        lane;
    logic              is_byte;
    logic              is_half;
    logic [3:0]        be_sel;
    logic [ADDR_W-1:0] st_data;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [ADDR_W-1:0] ld_data;
    logic              skip_base;

    assign accept    = bus.valid_in & (state_q == IDLE);
    assign acked     = (state_q == ACCESS) & bus.mem_ack_in;
    assign list_rest = list_q & (list_q - 16'd1);
    assign more      = mult_q & (|list_rest);
    assign lane      = addr_q[1:0];
    assign is_byte   = ~mult_q & (size_q == 2'b01);
    assign is_half   = ~mult_q & (size_q == 2'b10);

    // An LDM that reloads its own base keeps the loaded value.
    assign skip_base = bus.ld_str_in & bus.multiple_en_in
                     & bus.reg_list_in[bus.rn_addr_in];

    always_comb begin
        cur_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (list_q[i]) cur_idx = 4'(i);
        end
    end

    always_comb begin
        be_sel = 4'b1111;
        unique case (1'b1)
            is_byte: be_sel = 4'b0001 << lane;
            is_half: be_sel = lane[1] ? 4'b1100 : 4'b0011;
            default: be_sel = 4'b1111;
        endcase
    end

    always_comb begin
        st_data = sdata_q;
        unique case (1'b1)
            mult_q:  st_data = bus.rf_rd_data_in;
            is_byte: st_data = {4{sdata_q[7:0]}};
            is_half: st_data = {2{sdata_q[15:0]}};
            default: st_data = sdata_q;
        endcase
    end

    always_comb begin
        ld_byte = 8'h00;
        unique case (lane)
            2'd0: ld_byte = bus.mem_rdata_in[7:0];
            2'd1: ld_byte = bus.mem_rdata_in[15:8];
            2'd2: ld_byte = bus.mem_rdata_in[23:16];
            2'd3: ld_byte = bus.mem_rdata_in[31:24];
            default: ld_byte = 8'h00;
        endcase
    end

    assign ld_half = lane[1] ? bus.mem_rdata_in[31:16]
                             : bus.mem_rdata_in[15:0];

    always_comb begin
        ld_data = bus.mem_rdata_in;
        unique case (1'b1)
            is_byte: ld_data = {{(ADDR_W-8){1'b0}}, ld_byte};
            is_half: ld_data = {{(ADDR_W-16){1'b0}}, ld_half};
            default: ld_data = bus.mem_rdata_in;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    if (!bus.instr_exec_in) begin
                        state_d = FINISH;
                    end else if (bus.multiple_en_in
                                 && bus.reg_list_in == 16'd0) begin
                        state_d = bus.base_wb_en_in ? WB_BASE : FINISH;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (bus.mem_ack_in && !more) begin
                    state_d = bwb_q ? WB_BASE : FINISH;
                end
            end
            // Hold while the final load still owns the write port.
            WB_BASE: state_d = wb_en_q ? WB_BASE : FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            tag_q     <= '0;
            ld_q      <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= '0;
            sdata_q   <= '0;
            rd_q      <= 4'd0;
            mult_q    <= 1'b0;
            list_q    <= 16'd0;
            rn_q      <= 4'd0;
            rn_data_q <= '0;
            bwb_q     <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= 4'd0;
            wb_data_q <= '0;
        end else begin
            wb_en_q <= acked & ld_q;
            if (acked && ld_q) begin
                wb_addr_q <= mult_q ? cur_idx : rd_q;
                wb_data_q <= ld_data;
            end
            if (accept) begin
                tag_q     <= bus.instr_tag_in;
                ld_q      <= bus.ld_str_in;
                size_q    <= bus.size_in;
                addr_q    <= bus.addr_in;
                sdata_q   <= bus.str_data_in;
                rd_q      <= bus.rd_addr_in;
                mult_q    <= bus.multiple_en_in;
                list_q    <= bus.reg_list_in;
                rn_q      <= bus.rn_addr_in;
                rn_data_q <= bus.rn_data_in;
                bwb_q     <= bus.base_wb_en_in & ~skip_base;
            end else if (acked) begin
                list_q <= list_rest;
                addr_q <= addr_q + ADDR_W'(4);
            end
        end
    end

    assign bus.rf_rd_addr_out =
        (state_q == ACCESS && mult_q && !ld_q) ? cur_idx : 4'd0;

    always_comb begin
        bus.ready_out     = 1'b0;
        bus.mem_req_out   = 1'b0;
        bus.mem_we_out    = 1'b0;
        bus.mem_addr_out  = '0;
        bus.mem_be_out    = 4'b0000;
        bus.mem_wdata_out = '0;
        bus.wb_en_out     = 1'b0;
        bus.wb_addr_out   = 4'd0;
        bus.wb_data_out   = '0;
        bus.done_out      = 1'b0;
        bus.done_tag_out  = '0;
        unique case (state_q)
            IDLE: bus.ready_out = 1'b1;
            ACCESS: begin
                bus.mem_req_out  = 1'b1;
                bus.mem_we_out   = ~ld_q;
                bus.mem_addr_out = {addr_q[ADDR_W-1:2], 2'b00};
                bus.mem_be_out   = be_sel;
                if (!ld_q) bus.mem_wdata_out = st_data;
            end
            FINISH: begin
                bus.done_out     = 1'b1;
                bus.done_tag_out = tag_q;
            end
            default: ;
        endcase
        if (wb_en_q) begin
            bus.wb_en_out   = 1'b1;
            bus.wb_addr_out = wb_addr_q;
            bus.wb_data_out = wb_data_q;
        end else if (state_q == WB_BASE) begin
            bus.wb_en_out   = 1'b1;
            bus.wb_addr_out = rn_q;
            bus.wb_data_out = rn_data_q;
        end
    end

endmodule

// File: tb/tb_load_store_mem_access_stage.sv
// Scoreboard bench for load_store_mem_access_stage: expected requests,
// writebacks and done tags are queued at issue and popped on output.
module tb_load_store_mem_access_stage;

    localparam int TAG_W = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_store_mem_access_stage_if #(.TAG_W(TAG_W), .ADDR_W(32)) bus();

    load_store_mem_access_stage #(.TAG_W(TAG_W), .ADDR_W(32)) dut (
        .clk_in  (clk),
        .reset_in(rst),
        .bus     (bus)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        chk_rf;
        logic [3:0]  rf;
    } req_t;

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
        logic        ld;
    } wb_t;

    typedef struct {
        logic [5:0]  tag;
        logic        ex;
        logic        ld;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [3:0]  rd;
        logic        mu;
        logic [15:0] list;
        logic [3:0]  rn;
        logic [31:0] rnd;
        logic        bwb;
    } op_t;

    req_t       req_q[$];
    wb_t        wb_q[$];
    logic [5:0] done_q[$];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int ack_cyc = -10;
    int wait_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [31:0] rf_val(input logic [3:0] r);
        return {16'hC0DE, 4'h0, r, 4'h0, r};
    endfunction

    assign bus.rf_rd_data_in = rf_val(bus.rf_rd_addr_out);

    function automatic op_t mk(
        input logic [5:0] tag, input logic ex, input logic ld,
        input logic [1:0] size, input logic [31:0] addr,
        input logic [31:0] sdata, input logic [3:0] rd,
        input logic mu, input logic [15:0] list,
        input logic [3:0] rn, input logic [31:0] rnd, input logic bwb);
        op_t o;
        o.tag = tag; o.ex = ex; o.ld = ld; o.size = size;
        o.addr = addr; o.sdata = sdata; o.rd = rd; o.mu = mu;
        o.list = list; o.rn = rn; o.rnd = rnd; o.bwb = bwb;
        return o;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory responder: ack after wait_cyc idle cycles of a pending req.
    initial begin
        int cnt;
        cnt = 0;
        bus.mem_ack_in   = 1'b0;
        bus.mem_rdata_in = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !bus.mem_req_out) begin
                bus.mem_ack_in = 1'b0;
                cnt = 0;
            end else if (cnt >= wait_cyc) begin
                bus.mem_ack_in   = 1'b1;
                bus.mem_rdata_in = mem_val(bus.mem_addr_out);
                cnt = 0;
            end else begin
                bus.mem_ack_in = 1'b0;
                cnt++;
            end
        end
    end

    initial forever begin
        req_t r;
        wb_t  w;
        @(negedge clk);
        if (!rst) begin
            if (bus.wb_en_out) begin
                if (wb_q.size() == 0) begin
                    chk("unexp_wb", 64'(bus.wb_addr_out), 64'hFF);
                end else begin
                    w = wb_q.pop_front();
                    chk("wb_addr", 64'(bus.wb_addr_out), 64'(w.a));
                    chk("wb_data", 64'(bus.wb_data_out), 64'(w.d));
                    if (w.ld) chk("wb_lat", 64'(cyc), 64'(ack_cyc + 1));
                end
            end
            if (bus.mem_req_out) begin
                if (req_q.size() == 0) begin
                    chk("unexp_req", 64'(bus.mem_addr_out), 64'hFFFF_FFFF);
                end else begin
                    r = req_q[0];
                    chk("req_we", 64'(bus.mem_we_out), 64'(r.we));
                    chk("req_addr", 64'(bus.mem_addr_out), 64'(r.addr));
                    chk("req_be", 64'(bus.mem_be_out), 64'(r.be));
                    if (r.we) chk("req_wd", 64'(bus.mem_wdata_out), 64'(r.wd));
                    if (r.chk_rf) chk("rf_idx", 64'(bus.rf_rd_addr_out), 64'(r.rf));
                    if (bus.mem_ack_in) begin
                        void'(req_q.pop_front());
                        ack_cyc = cyc;
                    end
                end
            end
            if (bus.done_out) begin
                if (done_q.size() == 0) begin
                    chk("unexp_done", 64'(bus.done_tag_out), 64'hFF);
                end else begin
                    chk("done_tag", 64'(bus.done_tag_out), 64'(done_q.pop_front()));
                end
            end
        end
    end

    task automatic exp_op(input op_t o);
        req_t r;
        wb_t  w;
        int   k;
        logic [31:0] ad;
        logic [31:0] ldv;
        if (o.ex) begin
            if (o.mu) begin
                k = 0;
                for (int i = 0; i < 16; i++) begin
                    if (o.list[i]) begin
                        r.we = !o.ld;
                        r.addr = {o.addr[31:2], 2'b00} + 32'(4 * k);
                        r.be = 4'hF;
                        r.wd = rf_val(4'(i));
                        r.chk_rf = !o.ld;
                        r.rf = 4'(i);
                        req_q.push_back(r);
                        if (o.ld) begin
                            w.a = 4'(i); w.d = mem_val(r.addr); w.ld = 1'b1;
                            wb_q.push_back(w);
                        end
                        k++;
                    end
                end
                if (o.bwb && !(o.ld && o.list[o.rn])) begin
                    w.a = o.rn; w.d = o.rnd; w.ld = 1'b0;
                    wb_q.push_back(w);
                end
            end else begin
                ad = {o.addr[31:2], 2'b00};
                r.we = !o.ld; r.addr = ad; r.chk_rf = 1'b0; r.rf = 4'd0;
                case (o.size)
                    2'b01: begin
                        r.be = 4'b0001 << o.addr[1:0];
                        r.wd = {4{o.sdata[7:0]}};
                        ldv = (mem_val(ad) >> (8 * o.addr[1:0])) & 32'hFF;
                    end
                    2'b10: begin
                        r.be = o.addr[1] ? 4'b1100 : 4'b0011;
                        r.wd = {2{o.sdata[15:0]}};
                        ldv = (mem_val(ad) >> (16 * o.addr[1])) & 32'hFFFF;
                    end
                    default: begin
                        r.be = 4'b1111;
                        r.wd = o.sdata;
                        ldv = mem_val(ad);
                    end
                endcase
                req_q.push_back(r);
                if (o.ld) begin
                    w.a = o.rd; w.d = ldv; w.ld = 1'b1;
                    wb_q.push_back(w);
                end
                if (o.bwb) begin
                    w.a = o.rn; w.d = o.rnd; w.ld = 1'b0;
                    wb_q.push_back(w);
                end
            end
        end
        done_q.push_back(o.tag);
    endtask

    task automatic drive_op(input op_t o);
        int t;
        t = 0;
        while (!bus.ready_out && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("ready_wait", 64'(bus.ready_out), 64'd1);
        bus.valid_in       = 1'b1;
        bus.instr_tag_in   = o.tag;
        bus.instr_exec_in  = o.ex;
        bus.ld_str_in      = o.ld;
        bus.size_in        = o.size;
        bus.addr_in        = o.addr;
        bus.str_data_in    = o.sdata;
        bus.rd_addr_in     = o.rd;
        bus.multiple_en_in = o.mu;
        bus.reg_list_in    = o.list;
        bus.rn_addr_in     = o.rn;
        bus.rn_data_in     = o.rnd;
        bus.base_wb_en_in  = o.bwb;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
    endtask

    task automatic flush();
        req_q.delete();
        wb_q.delete();
        done_q.delete();
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done_q.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("done_seen", 64'(done_q.size()), 64'd0);
        @(posedge clk);
        #1;
        chk("req_left", 64'(req_q.size()), 64'd0);
        chk("wb_left", 64'(wb_q.size()), 64'd0);
        flush();
    endtask

    task automatic run(input op_t o, input int wc);
        wait_cyc = wc;
        exp_op(o);
        drive_op(o);
        wait_done();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, 64'(bus.ready_out), 64'd1);
        chk({tag, "_req"}, 64'(bus.mem_req_out), 64'd0);
        chk({tag, "_we"}, 64'(bus.mem_we_out), 64'd0);
        chk({tag, "_be"}, 64'(bus.mem_be_out), 64'd0);
        chk({tag, "_wb"}, 64'(bus.wb_en_out), 64'd0);
        chk({tag, "_done"}, 64'(bus.done_out), 64'd0);
    endtask

    initial begin
        op_t o;
        int  t;
        bus.valid_in       = 1'b0;
        bus.instr_tag_in   = '0;
        bus.instr_exec_in  = 1'b0;
        bus.ld_str_in      = 1'b0;
        bus.size_in        = 2'b00;
        bus.addr_in        = 32'h0;
        bus.str_data_in    = 32'h0;
        bus.rd_addr_in     = 4'd0;
        bus.multiple_en_in = 1'b0;
        bus.reg_list_in    = 16'h0;
        bus.rn_addr_in     = 4'd0;
        bus.rn_data_in     = 32'h0;
        bus.base_wb_en_in  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_idle("rst");
        rst = 1'b0;
        @(posedge clk);
        #1;

        run(mk(6'd1, 1, 1, 2'b00, 32'h100, 0, 4'd3, 0, 16'h0, 0, 0, 0), 2);
        run(mk(6'd2, 1, 0, 2'b01, 32'h203, 32'h5A, 0, 0, 16'h0, 0, 0, 0), 1);
        run(mk(6'd3, 1, 1, 2'b00, 32'h40, 0, 0, 1, 16'h8005, 4'd1, 32'h4C, 1), 0);
        run(mk(6'd4, 1, 0, 2'b00, 32'h80, 0, 0, 1, 16'h0012, 0, 0, 0), 0);
        run(mk(6'd5, 0, 0, 2'b00, 32'h90, 32'h1, 0, 0, 16'h0, 4'd2, 32'h5, 1), 0);
        run(mk(6'd6, 1, 0, 2'b10, 32'h302, 32'h1234ABCD, 0, 0, 16'h0, 0, 0, 0), 1);
        run(mk(6'd7, 1, 1, 2'b01, 32'h101, 0, 4'd5, 0, 16'h0, 0, 0, 0), 0);
        run(mk(6'd8, 1, 1, 2'b10, 32'h102, 0, 4'd6, 0, 16'h0, 4'd2, 32'h77, 1), 1);
        run(mk(6'd9, 1, 1, 2'b00, 32'h500, 0, 0, 1, 16'h0006, 4'd2, 32'h508, 1), 0);
        run(mk(6'd10, 1, 1, 2'b00, 32'h600, 0, 0, 1, 16'h0000, 4'd7, 32'h5FC, 1), 0);
        run(mk(6'd11, 1, 0, 2'b11, 32'h13, 32'h89ABCDEF, 0, 0, 16'h0, 0, 0, 0), 0);

        // Reset while an LDM request is stalled waiting for ack.
        wait_cyc = 30;
        o = mk(6'd12, 1, 1, 2'b00, 32'h200, 0, 0, 1, 16'h00F0, 4'd3, 0, 1);
        exp_op(o);
        drive_op(o);
        t = 0;
        while (!bus.mem_req_out && t < 10) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("mid_req", 64'(bus.mem_req_out), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("midrst");
        flush();
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(mk(6'd13, 1, 1, 2'b00, 32'h104, 0, 4'd9, 0, 16'h0, 0, 0, 0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
